sdram_port_arbiter: RTL and testbench

Two-master arbiter sharing the single Avalon-MM slave port of the SDRAM controller inside the Nios system. Master 0 is the Nios II data path; master 1 is a local requester (LED pattern buffer / DMA). The block grants one master at a time, holds the command stable under waitrequest, and routes pipelined read data back to the master that issued each read.

---
 rtl/sdram_port_arbiter.sv | 138 +++++++++++++
 tb/tb_sdram_port_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: two-master round-robin arbiter in front of one Avalon-MM SDRAM slave.
// Optional macro ARB_FIXED_PRIORITY_EN makes master 0 win every tie.  Rev 1.0
`default_nettype none

module sdram_port_arbiter #(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 32,
  parameter int BE_W     = 4,
  parameter int MAX_PEND = 4
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  input  logic [BE_W-1:0]   m0_byteenable,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  input  logic [BE_W-1:0]   m1_byteenable,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] s_address,
  output logic [DATA_W-1:0] s_writedata,
  output logic [BE_W-1:0]   s_byteenable,
  output logic              s_read,
  output logic              s_write,
  input  logic              s_waitrequest,
  input  logic [DATA_W-1:0] s_readdata,
  input  logic              s_readdatavalid,
  output logic              arb_error
);

  localparam int PTR_W = $clog2(MAX_PEND);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_PEND);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state, state_nxt;
  logic             grant, grant_nxt;
  logic             tag_q [MAX_PEND];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] pend_count;

  logic sel_read, sel_write, busy, read_blocked, accept;
  logic push, pop, head, tie_winner;

`ifdef ARB_FIXED_PRIORITY_EN
  assign tie_winner = 1'b0;
`else
  logic last_grant;
  assign tie_winner = ~last_grant;
`endif

  // Command mux: outputs are gated by reset so nothing escapes before the first edge.
  always_comb begin
    sel_read     = grant ? m1_read : m0_read;
    sel_write    = grant ? m1_write : m0_write;
    busy         = (state == BUSY) & reset_reset_n;
    read_blocked = busy & sel_read & (pend_count == FULL);
    s_read       = busy & sel_read & ~read_blocked;
    s_write      = busy & sel_write;
    s_address    = grant ? m1_address : m0_address;
    s_writedata  = grant ? m1_writedata : m0_writedata;
    s_byteenable = grant ? m1_byteenable : m0_byteenable;
    accept       = (s_read | s_write) & ~s_waitrequest;
    m0_waitrequest = ~(busy & ~grant & ~s_waitrequest & ~read_blocked);
    m1_waitrequest = ~(busy & grant & ~s_waitrequest & ~read_blocked);
  end

  // Read return routing follows the oldest outstanding tag.
  always_comb begin
    head             = tag_q[rd_ptr];
    pop              = reset_reset_n & s_readdatavalid & (pend_count != '0);
    push             = accept & s_read;
    m0_readdatavalid = pop & ~head;
    m1_readdatavalid = pop & head;
    m0_readdata      = s_readdata;
    m1_readdata      = s_readdata;
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    case (state)
      IDLE: begin
        if (m0_read | m0_write | m1_read | m1_write) begin
          state_nxt = BUSY;
          if ((m0_read | m0_write) & (m1_read | m1_write)) grant_nxt = tie_winner;
          else                                             grant_nxt = m1_read | m1_write;
        end
      end
      BUSY: begin
        // Also leave when the granted master withdraws its request.
        if (accept | ~(sel_read | sel_write)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      last_grant <= 1'b1;
`endif
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      pend_count <= '0;
      arb_error  <= 1'b0;
    end else begin
      state <= state_nxt;
      grant <= grant_nxt;
`ifndef ARB_FIXED_PRIORITY_EN
      if (accept) last_grant <= grant;
`endif
      if (push) begin
        tag_q[wr_ptr] <= grant;
        wr_ptr        <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (push & ~pop)      pend_count <= pend_count + CNT_W'(1);
      else if (pop & ~push) pend_count <= pend_count - CNT_W'(1);
      if (s_readdatavalid & (pend_count == '0)) arb_error <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed + randomized checks against a transaction-level reference model.
`default_nettype none

module tb_sdram_port_arbiter;
  localparam int ADDR_W = 25, DATA_W = 32, BE_W = 4, MAX_PEND = 4;

  logic clk_clk = 1'b0;
  logic reset_reset_n = 1'b0;
  logic              mrd [2];
  logic              mwr [2];
  logic [ADDR_W-1:0] maddr [2];
  logic [DATA_W-1:0] mwd [2];
  logic [BE_W-1:0]   mbe [2];
  logic              m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, s_writedata;
  logic [ADDR_W-1:0] s_address;
  logic [BE_W-1:0]   s_byteenable;
  logic              s_read, s_write, arb_error;
  logic              s_waitrequest = 1'b0, s_readdatavalid = 1'b0;
  logic [DATA_W-1:0] s_readdata = '0;

  sdram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BE_W(BE_W), .MAX_PEND(MAX_PEND)) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .m0_address(maddr[0]), .m0_read(mrd[0]), .m0_write(mwr[0]), .m0_writedata(mwd[0]),
    .m0_byteenable(mbe[0]), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(maddr[1]), .m1_read(mrd[1]), .m1_write(mwr[1]), .m1_writedata(mwd[1]),
    .m1_byteenable(mbe[1]), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .s_address(s_address), .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_read(s_read), .s_write(s_write), .s_waitrequest(s_waitrequest),
    .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid), .arb_error(arb_error)
  );

  always #5 clk_clk = ~clk_clk;

  int n_assert = 0, n_fail = 0;
  // Reference model: open transaction (busy/owner), round-robin history, issuer queue, sticky error.
  bit busy = 0, err = 0;
  int owner = 0, last_g = 1;
  int pend[$];
  // Controller model: due cycle for each outstanding read return.
  int due[$];
  int cyc = 0, mode = 0, lat_fix = 0;
  bit hold = 0, spur = 0, rnd_sw = 0;
  bit acc [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step_cycle();
    bit full, ord, owr, e_sr, e_sw, a;
    bit e_wait [2];
    bit e_rdv [2];
    int lat;
    for (int n = 0; n < 2; n++) begin
      if (!mrd[n] && !mwr[n] && mode != 0) begin
        maddr[n] = ADDR_W'($urandom);
        mwd[n]   = $urandom;
        mbe[n]   = BE_W'($urandom);
        if (mode == 2) mrd[n] = 1'b1;
        else case ($urandom_range(0, 3))
          1:       mwr[n] = 1'b1;
          2, 3:    mrd[n] = 1'b1;
          default: ;
        endcase
      end
    end
    if (rnd_sw) s_waitrequest = ($urandom_range(0, 3) == 0);
    s_readdatavalid = spur || (!hold && due.size() > 0 && due[0] <= cyc);
    s_readdata = $urandom;
    #4;
    full = (pend.size() == MAX_PEND);
    ord  = busy && mrd[owner];
    owr  = busy && mwr[owner];
    e_sr = reset_reset_n && ord && !full;
    e_sw = reset_reset_n && owr;
    for (int n = 0; n < 2; n++) begin
      e_wait[n] = !(reset_reset_n && busy && owner == n && !s_waitrequest && !(ord && full));
      e_rdv[n]  = reset_reset_n && s_readdatavalid && pend.size() > 0 && pend[0] == n;
    end
    chk("s_read", s_read, e_sr);
    chk("s_write", s_write, e_sw);
    chk("m0_waitrequest", m0_waitrequest, e_wait[0]);
    chk("m1_waitrequest", m1_waitrequest, e_wait[1]);
    chk("m0_readdatavalid", m0_readdatavalid, e_rdv[0]);
    chk("m1_readdatavalid", m1_readdatavalid, e_rdv[1]);
    chk("m0_readdata", m0_readdata, s_readdata);
    chk("m1_readdata", m1_readdata, s_readdata);
    chk("arb_error", arb_error, err);
    if (e_sr || e_sw) begin
      chk("s_address", s_address, maddr[owner]);
      chk("s_byteenable", s_byteenable, mbe[owner]);
    end
    if (e_sw) chk("s_writedata", s_writedata, mwd[owner]);

    a = (e_sr || e_sw) && !s_waitrequest;
    for (int n = 0; n < 2; n++) acc[n] = reset_reset_n && !e_wait[n] && (mrd[n] || mwr[n]);
    if (!reset_reset_n) begin
      busy = 0; last_g = 1; err = 0; owner = 0;
      pend.delete(); due.delete();
    end else begin
      if (s_readdatavalid) begin
        if (pend.size() > 0) void'(pend.pop_front());
        else err = 1;
        if (!spur && due.size() > 0) void'(due.pop_front());
      end
      if (a && e_sr) begin
        pend.push_back(owner);
        lat = (lat_fix > 0) ? lat_fix : $urandom_range(1, 4);
        if (due.size() > 0 && due[$] >= cyc + lat) due.push_back(due[$] + 1);
        else due.push_back(cyc + lat);
      end
      if (busy) begin
        if (a) begin last_g = owner; busy = 0; end
        else if (!ord && !owr) busy = 0;
      end else if (mrd[0] || mwr[0] || mrd[1] || mwr[1]) begin
        busy = 1;
        if ((mrd[0] || mwr[0]) && (mrd[1] || mwr[1])) begin
`ifdef ARB_FIXED_PRIORITY_EN
          owner = 0;
`else
          owner = 1 - last_g;
`endif
        end else owner = (mrd[1] || mwr[1]) ? 1 : 0;
      end
    end
    spur = 0;
    @(posedge clk_clk); #1;
    for (int n = 0; n < 2; n++) if (acc[n]) begin mrd[n] = 1'b0; mwr[n] = 1'b0; end
    cyc++;
  endtask

  task automatic drain();
    mode = 0; hold = 0; rnd_sw = 0; s_waitrequest = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (pend.size() == 0 && !busy && !mrd[0] && !mwr[0] && !mrd[1] && !mwr[1]) break;
      step_cycle();
    end
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      mrd[n] = 1'b0; mwr[n] = 1'b0; maddr[n] = '0; mwd[n] = '0; mbe[n] = '0;
    end
    // Reset
    @(posedge clk_clk); #1;
    repeat (2) step_cycle();
    reset_reset_n = 1'b1;
    step_cycle();

    // Single m0 write
    maddr[0] = 25'h0000123; mwd[0] = 32'hDEADBEEF; mbe[0] = 4'hF; mwr[0] = 1'b1;
    step_cycle();
    chk("p2_s_write_on", s_write, 1'b1);
    chk("p2_m0_wait_low", m0_waitrequest, 1'b0);
    chk("p2_wdata", s_writedata, 32'hDEADBEEF);
    chk("p2_addr", s_address, 25'h0000123);
    step_cycle();
    chk("p2_s_write_off", s_write, 1'b0);
    step_cycle();

    // Both masters reading continuously, 3-cycle return latency
    mode = 2; lat_fix = 3;
    repeat (40) step_cycle();
    drain();
    lat_fix = 0;

    // Outstanding-read limit with withheld returns
    mode = 2; hold = 1;
    repeat (12) step_cycle();
    chk("p4_blocked_sread", s_read, 1'b0);
    hold = 0; step_cycle();
    hold = 1;
    repeat (4) step_cycle();
    drain();

    // Command held stable under waitrequest
    s_waitrequest = 1'b1;
    maddr[1] = 25'h0ABCDEF; mwd[1] = 32'hCAFEF00D; mbe[1] = 4'h5; mwr[1] = 1'b1;
    step_cycle();
    maddr[0] = 25'h0000456; mwd[0] = 32'h12345678; mbe[0] = 4'hF; mwr[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step_cycle();
      chk("p5_addr_hold", s_address, 25'h0ABCDEF);
      chk("p5_wdata_hold", s_writedata, 32'hCAFEF00D);
      chk("p5_write_hold", s_write, 1'b1);
      chk("p5_m0_ignored", m0_waitrequest, 1'b1);
    end
    s_waitrequest = 1'b0;
    step_cycle();
    drain();

    // Randomized traffic
    mode = 1; rnd_sw = 1;
    repeat (600) step_cycle();
    drain();

    // Spurious return, then reset clears the sticky error
    spur = 1;
    step_cycle();
    chk("p7_err_set", arb_error, 1'b1);
    chk("p7_no_rdv0", m0_readdatavalid, 1'b0);
    step_cycle();
    chk("p7_err_hold", arb_error, 1'b1);
    reset_reset_n = 1'b0;
    step_cycle();
    reset_reset_n = 1'b1;
    chk("p7_err_clr", arb_error, 1'b0);
    chk("p7_sread_rst", s_read, 1'b0);
    chk("p7_m0_wait_rst", m0_waitrequest, 1'b1);
    step_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
